sw_ctrl_lap: RTL
================

Name: sw_ctrl_lap

Overview:
Parametrised next-generation stopwatch controller.
- Decodes start/stop, clear and lap buttons.
- Owns an N-digit BCD elapsed-time counter that advances on the 1 ms tick m_sec, counting up, or down from a preset.
- Supports a lap (split) display freeze.
- Sits between the debounced button inputs and the display driver.
- timer_on and timer_clr remain available for the legacy timer path.

Parameters:
DIGITS, 4, number of BCD digits in the counter and display (1..8).
BW, 4*DIGITS, derived bus width; do not override.

Ports:
clk  in  1  system clock
rst_btn  in  1  asynchronous active-high reset
ss_btn  in  1  start/stop button, debounced level, synchronous to clk
c_btn  in  1  clear button, debounced level
lap_btn  in  1  lap button, debounced level
m_sec  in  1  1 ms tick, one clk cycle wide
mode  in  1  0 = count up, 1 = count down; sampled only in IDLE
preset  in  BW  BCD countdown start value; sampled only in IDLE
timer_on  out  1  high while in RUN
timer_clr  out  1  clear strobe to legacy timer
lap_hold  out  1  display frozen
disp_bcd  out  BW  displayed BCD value
done  out  1  countdown reached zero

Behaviour:
- Reset is asynchronous and active-high on rst_btn, with one clock clk. While rst_btn=1:
  - state=IDLE, count=0, disp_bcd=0, lap_hold=0, done=0, timer_on=0.
  - timer_clr=1 combinationally, i.e. without waiting for a clock edge.
- timer_clr = rst_btn OR clr_q. clr_q is a registered one-cycle pulse.
- Button edges: each button has a registered previous-value flop. edge = btn & ~btn_q. A button held high produces exactly one edge.
- Latency: an input stable before posedge k takes effect at posedge k. timer_on and disp_bcd change after that edge.
- State machine states: IDLE, RUN, STOP, DONE.
  - IDLE: the count is held at 0 if mode=0, or at preset if mode=1. The mode value is latched as dir.
    - ss edge -> RUN.
    - Exception: if mode=1 and preset=0, ss is ignored and the block stays in IDLE.
  - RUN: on each m_sec, count steps by one in BCD (+1 if dir=0, -1 if dir=1).
    - ss edge -> STOP.
    - c edge is ignored.
    - If dir=1 and the count steps from 1 to 0 -> DONE.
  - STOP: the count is held.
    - c edge -> IDLE, with clr_q=1 for one cycle and lap_hold cleared. c has priority over ss when both edge in the same cycle.
    - ss edge -> RUN.
  - DONE: count=0, done=1.
    - c edge -> IDLE, with the clr_q pulse and done cleared.
    - ss and lap are ignored.
- Up-count wrap: all digits 9 plus one tick wraps to 0 and counting continues. No flag is raised.
- Each BCD digit stays in 0..9. Carry and borrow ripple within the same cycle.
- An m_sec tick in the same cycle as an ss stop edge is counted, because the decision uses the current state (RUN).
- Lap:
  - In RUN, a lap edge toggles lap_hold.
  - On the 0->1 transition of lap_hold, disp_bcd captures the count value that exists after that cycle's update.
  - In STOP, a lap edge only clears lap_hold.
  - lap edges in IDLE and DONE are ignored.
- disp_bcd equals count when lap_hold=0 and equals the captured value when lap_hold=1. The internal count keeps running while held.
- mode and preset changes outside IDLE have no effect.
- rst_btn asserted in any state, mid-count or with lap held, aborts immediately to the reset values above.

Decomposition:
- Package sw_pkg holds:
  - the state enum/localparams: IDLE=2'd0, RUN=2'd1, STOP=2'd2, DONE=2'd3;
  - BCD constants: DIG_MAX=4'd9, DIG_MIN=4'd0.
- Sub-module bcd_digit_ud: one 4-bit up/down digit with enable, carry/borrow in, carry/borrow out and an async reset. It is instantiated DIGITS times via a generate loop.
- The controller FSM, edge detection and lap latch stay in sw_ctrl_lap.

Test Plan:
1. rst_btn=1 mid-RUN with count 0042 -> 1 ns later timer_clr=1; count and disp 0000, timer_on=0 before the next clk edge.
2. mode=0, ss pulse, 12 m_sec ticks, ss pulse -> timer_on 1 then 0, disp_bcd=0x0012. c pulse -> timer_clr high exactly one cycle, disp 0x0000, state IDLE.
3. mode=1, preset=0x0003, ss, 3 ticks -> disp 0x0000, done=1, timer_on=0. ss ignored. c -> done=0, disp reloads to 0x0003. With preset=0x0000, ss leaves timer_on=0.
4. Run to 0x0005, lap pulse -> lap_hold=1 and disp stays 0x0005 through 4 more ticks. Lap again -> disp=0x0009.
5. From STOP at 0x0007, assert ss and c edges in the same cycle -> IDLE, clear pulse, timer_on stays 0. In RUN, an m_sec tick and an ss edge in the same cycle -> count 0x0008, then STOP.
6. DIGITS=2, preload by running to 0x99, one tick -> 0x00 and timer_on stays 1. A held ss (10 cycles high) toggles state once only.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digit cells.
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] DIG_MAX = 4'd9;
    localparam logic [3:0] DIG_MIN = 4'd0;

    // A non-decimal nibble from the preset bus is pinned to 9 so a digit never leaves 0..9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > DIG_MAX) ? DIG_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_ud.sv
// One BCD up/down digit: load, step on enable & carry-in, carry/borrow out, async reset.
module bcd_digit_ud
    import sw_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       dn,
    input  logic       cin,
    output logic [3:0] q,
    output logic [3:0] nxt,
    output logic       cout
);

    always_comb begin
        nxt  = q;
        cout = 1'b0;
        if (load) begin
            nxt = bcd_clamp(load_val);
        end else if (en && cin) begin
            if (!dn) begin
                if (q >= DIG_MAX) begin
                    nxt  = DIG_MIN;
                    cout = 1'b1;
                end else begin
                    nxt = q + 4'd1;
                end
            end else begin
                if (q == DIG_MIN) begin
                    nxt  = DIG_MAX;
                    cout = 1'b1;
                end else begin
                    nxt = q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= DIG_MIN;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/sw_ctrl_lap.sv
// Stopwatch controller: button edge decode, run/stop/countdown FSM, BCD counter and lap freeze.
module sw_ctrl_lap
    import sw_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BW     = 4 * DIGITS
) (
    input  logic          clk,
    input  logic          rst_btn,
    input  logic          ss_btn,
    input  logic          c_btn,
    input  logic          lap_btn,
    input  logic          m_sec,
    input  logic          mode,
    input  logic [BW-1:0] preset,
    output logic          timer_on,
    output logic          timer_clr,
    output logic          lap_hold,
    output logic [BW-1:0] disp_bcd,
    output logic          done
);

    state_t        state, state_nxt;
    logic          dir;
    logic          ss_q, c_q, lap_q;
    logic          ss_e, c_e, lap_e;
    logic          clr_q;
    logic          go_idle, hold_nxt, capture;
    logic          step, load, hit_zero;
    logic [BW-1:0] load_bus, count, count_nxt, lap_val;
    logic [DIGITS:0] carry;

    assign ss_e  = ss_btn  & ~ss_q;
    assign c_e   = c_btn   & ~c_q;
    assign lap_e = lap_btn & ~lap_q;

    assign step     = (state == RUN) && m_sec;
    assign load     = (state == IDLE) || go_idle;
    assign load_bus = mode ? preset : '0;
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_ud u_digit (
            .clk      (clk),
            .rst      (rst_btn),
            .load     (load),
            .load_val (load_bus[4*g +: 4]),
            .en       (step),
            .dn       (dir),
            .cin      (carry[g]),
            .q        (count[4*g +: 4]),
            .nxt      (count_nxt[4*g +: 4]),
            .cout     (carry[g+1])
        );
    end

    // Countdown landed on zero this cycle without borrowing out of the top digit.
    assign hit_zero = step && dir && (count_nxt == '0) && !carry[DIGITS];

    always_comb begin
        state_nxt = state;
        go_idle   = 1'b0;
        hold_nxt  = lap_hold;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_e && !(mode && (preset == '0))) state_nxt = RUN;
            end
            RUN: begin
                if (hit_zero)  state_nxt = DONE;
                else if (ss_e) state_nxt = STOP;
                if (lap_e) begin
                    hold_nxt = ~lap_hold;
                    capture  = ~lap_hold;
                end
            end
            STOP: begin
                if (c_e) begin
                    state_nxt = IDLE;
                    go_idle   = 1'b1;
                    hold_nxt  = 1'b0;
                end else begin
                    if (ss_e)  state_nxt = RUN;
                    if (lap_e) hold_nxt  = 1'b0;
                end
            end
            DONE: begin
                if (c_e) begin
                    state_nxt = IDLE;
                    go_idle   = 1'b1;
                    hold_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            state    <= IDLE;
            dir      <= 1'b0;
            ss_q     <= 1'b0;
            c_q      <= 1'b0;
            lap_q    <= 1'b0;
            clr_q    <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            state    <= state_nxt;
            ss_q     <= ss_btn;
            c_q      <= c_btn;
            lap_q    <= lap_btn;
            clr_q    <= go_idle;
            lap_hold <= hold_nxt;
            if (state == IDLE) dir <= mode;
        end
    end

    // Snapshot is only visible while lap_hold is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) lap_val <= count_nxt;
    end

    assign timer_on  = (state == RUN);
    assign done      = (state == DONE);
    assign timer_clr = rst_btn | clr_q;
    assign disp_bcd  = lap_hold ? lap_val : count;

endmodule
